sfft_frame_reader: RTL
======================

# sfft_frame_reader

Bus-read initiator for the SFFT accelerator's 1024-byte read-out window; it is the requesting end of the `chipselect`/`address`/`readdata` byte interface that the accelerator answers. On a `start` pulse it holds `chipselect` high for the whole sweep, which freezes a coherent snapshot of the window. It reads `NUM_WORDS` consecutive 32-bit words one byte at a time, reassembles each word little-endian, and streams the words out on a valid/ready port. It feeds on-chip consumers such as peak finding and fingerprinting, which then need no software in the loop.

## Interface
- `NUM_WORDS`, 256: words per frame. Word 0 is the time counter and word k is FFT bin k-1. The constraint `4*NUM_WORDS + BASE_ADDR <= 1024` is checked at elaboration.
- `BASE_ADDR`, 0: byte address of word 0.
- `IDX_W`, `$clog2(NUM_WORDS)`: width of `word_index`.
- `clk` in 1: single clock for the block.
- `reset` in 1: asynchronous, active-low. All state and outputs clear while low.
- `start` in 1: one-cycle request to sweep a frame. It is ignored while `busy` is high.
- `abort` in 1: ends a sweep immediately. No `done` pulse is produced.
- `chipselect` out 1: frame-snapshot hold toward the accelerator.
- `address` out 16: byte address presented to the accelerator.
- `readdata` in 8: byte returned by the accelerator, registered one cycle after `address`.
- `word_valid` out 1: the value on `word_data` is valid.
- `word_ready` in 1: the consumer accepts the word.
- `word_data` out 32: reassembled word.
- `word_index` out IDX_W: index of the word within the frame.
- `busy` out 1: high from the cycle after an accepted `start` until the return to IDLE.
- `done` out 1: one-cycle pulse when the last word is accepted.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
  - IDLE: `start` while `abort` is low → ISSUE with w=0, b=0.
  - ISSUE: lasts 4 cycles with b=0..3. `address` = `BASE_ADDR + 4w + b`. After b=3 → WAIT.
  - WAIT: lasts 1 cycle → OUT.
  - OUT: `word_valid` is high. On `word_ready`:
    - if w < NUM_WORDS-1: w++ → ISSUE;
    - else: `done` pulses → IDLE.
- Capture: the byte addressed in ISSUE cycle c (c=0..3) appears on `readdata` in cycle c+1 and is registered at the end of that cycle into `word_data[8c+7:8c]`. Byte 3 therefore lands at the end of the WAIT cycle.
- Byte order: the lowest byte address is the least significant byte. This matches the accelerator's pre-reversed layout, so no byte swap is needed.
- `chipselect`: high in ISSUE, WAIT and OUT, low in IDLE. It stays high through backpressure stalls in OUT, so the snapshot remains frozen for the entire frame.
- `word_index` = w. It is stable for the whole ISSUE/WAIT/OUT sequence of a word.
- `word_data` and `word_index` hold their values while `word_valid` is high and `word_ready` is low.
- `abort` has priority in every state. The next cycle is IDLE, with `chipselect`, `word_valid`, `busy` and `done` all at 0. `start` and `abort` in the same cycle leave the block in IDLE.
- Backpressure in OUT is unbounded. There is no timeout.
- Reset mid-frame behaves like `abort`, except that all registers, including `word_data`, clear to 0.

## Timing
- Reset values: `chipselect`, `address`, `word_valid`, `word_data`, `word_index`, `busy` and `done` are all 0.
- With `start` high in IDLE at edge 0:
  - ISSUE occupies cycles 1-4 and `chipselect` rises in cycle 1;
  - WAIT is cycle 5;
  - `word_valid` is first high in cycle 6.
- Word period is 6 cycles with `word_ready` held high. Frame length is 6·NUM_WORDS cycles, i.e. 1536 for the default.
- `done` is high in the cycle after the final handshake. `chipselect` and `busy` fall in that same cycle.
- `address` returns to 0 in IDLE.
- A new `start` is accepted in the first IDLE cycle, which is the cycle where `done` is high.

## Structure
- Package `sfft_reader_pkg` holds:
  - constants `READOUT_BYTES` = 1024 and `BYTES_PER_WORD` = 4;
  - default `NUM_WORDS`;
  - the state enum typedef `reader_state_t`.
- One sub-module, `sfft_byte_assembler`. It registers a lane-select tag delayed one cycle and writes `readdata` into the selected byte of a 32-bit register. The FSM, address generation and handshake live in the top.

## Test plan
- **Basic frame.** Responder model returns byte `addr[7:0]` with 1-cycle latency; NUM_WORDS=4; `word_ready` tied high; pulse `start`.
  - Words are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, with indices 0-3.
  - First `word_valid` is in cycle 6; `done` is in cycle 25.
- **Backpressure.** Hold `word_ready` low for 10 cycles on word 1.
  - `word_data` and `word_index` stay stable.
  - `chipselect` stays high throughout.
  - There are no additional `address` changes.
- **Abort.** Assert `abort` during ISSUE of word 2.
  - Next cycle is IDLE: `chipselect`=0, `busy`=0, no `done`.
  - A later `start` restarts from word 0.
- **Start and reset edge cases.**
  - `start` while busy is ignored.
  - `start` and `abort` together in IDLE leave the block in IDLE.
  - `reset` low mid-OUT clears all outputs to 0 asynchronously, before the next edge.
- **Full default frame.** NUM_WORDS=256, BASE_ADDR=0, responder uses the accelerator test pattern.
  - Word 248 reads 0x11223344.
  - Word 255 reads 0x01234567.
  - Frame takes 1536 cycles.

Source files
------------

// File: rtl/sfft_reader_pkg.sv
// Shared constants and state type for the SFFT read-out window initiator.
// Imported by the frame reader top and its byte assembler.
package sfft_reader_pkg;

   localparam int READOUT_BYTES     = 1024;
   localparam int BYTES_PER_WORD    = 4;
   localparam int DEFAULT_NUM_WORDS = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT
   } reader_state_t;

endpackage

// File: rtl/sfft_byte_assembler.sv
// Rebuilds a 32-bit little-endian word from bytes that arrive one cycle
// after their address was issued; the lane tag is delayed to line up with them.
module sfft_byte_assembler
   import sfft_reader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        lane_en,
   input  logic [1:0]  lane_sel,
   input  logic [7:0]  readdata,
   output logic [31:0] word
);

   logic       lane_en_reg;
   logic [1:0] lane_sel_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_en_reg  <= 1'b0;
         lane_sel_reg <= '0;
      end else begin
         lane_en_reg  <= lane_en;
         lane_sel_reg <= lane_sel;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic [7:0] byte_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               byte_reg <= '0;
            else if (lane_en_reg && (lane_sel_reg == 2'(gi)))
               byte_reg <= readdata;
         end

         assign word[8*gi +: 8] = byte_reg;
      end
   endgenerate

endmodule

// File: rtl/sfft_frame_reader.sv
// Sweeps the accelerator read-out window byte by byte under a held chipselect
// and streams reassembled 32-bit words out on a valid/ready port.
module sfft_frame_reader
   import sfft_reader_pkg::*;
#(
   parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
   parameter int BASE_ADDR = 0,
   parameter int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             chipselect,
   output logic [15:0]      address,
   input  logic [7:0]       readdata,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [31:0]      word_data,
   output logic [IDX_W-1:0] word_index,
   output logic             busy,
   output logic             done
);

   generate
      if (BYTES_PER_WORD*NUM_WORDS + BASE_ADDR > READOUT_BYTES) begin : g_bad_cfg
         $error("sfft_frame_reader: frame does not fit in the read-out window");
      end
   endgenerate

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   reader_state_t    state_reg, state_next;
   logic [IDX_W-1:0] word_idx_reg, word_idx_next;
   logic [1:0]       byte_cnt_reg, byte_cnt_next;
   logic [15:0]      address_reg, address_next;
   logic             done_reg, done_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         word_idx_reg <= '0;
         byte_cnt_reg <= '0;
         address_reg  <= '0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         word_idx_reg <= word_idx_next;
         byte_cnt_reg <= byte_cnt_next;
         address_reg  <= address_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      word_idx_next = word_idx_reg;
      byte_cnt_next = byte_cnt_reg;
      done_next     = 1'b0;
      if (abort) begin
         state_next    = ST_IDLE;
         word_idx_next = '0;
         byte_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_next    = ST_ISSUE;
                  word_idx_next = '0;
                  byte_cnt_next = '0;
               end
            end
            ST_ISSUE: begin
               // Counter wraps 3 -> 0, so it is already cleared for the next word.
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3)
                  state_next = ST_WAIT;
            end
            ST_WAIT: state_next = ST_OUT;
            ST_OUT: begin
               if (word_ready) begin
                  if (word_idx_reg == LAST_IDX) begin
                     state_next    = ST_IDLE;
                     word_idx_next = '0;
                     done_next     = 1'b1;
                  end else begin
                     state_next    = ST_ISSUE;
                     word_idx_next = word_idx_reg + IDX_W'(1);
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end

      // Address is registered; it holds through WAIT and OUT stalls.
      if (state_next == ST_ISSUE)
         address_next = 16'(BASE_ADDR) + 16'({word_idx_next, byte_cnt_next});
      else if (state_next == ST_IDLE)
         address_next = '0;
      else
         address_next = address_reg;
   end

   sfft_byte_assembler u_assembler (
      .clk      (clk),
      .reset    (reset),
      .lane_en  ((state_reg == ST_ISSUE) && !abort),
      .lane_sel (byte_cnt_reg),
      .readdata (readdata),
      .word     (word_data)
   );

   assign chipselect = (state_reg != ST_IDLE);
   assign busy       = (state_reg != ST_IDLE);
   assign word_valid = (state_reg == ST_OUT);
   assign address    = address_reg;
   assign word_index = word_idx_reg;
   assign done       = done_reg;

endmodule
